// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART TX and RX paths.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b10,
    PAR_ODD  = 2'b11
  } parity_t;

  typedef enum logic [1:0] {
    DB5 = 2'b00,
    DB6 = 2'b01,
    DB7 = 2'b10,
    DB8 = 2'b11
  } data_bits_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } uart_rx_state_t;

  typedef struct packed {
    parity_t    parity;
    data_bits_t nbits;
    logic       two_stop;
  } rx_cfg_t;

  function automatic logic [3:0] data_bits_num(data_bits_t d);
    return 4'd5 + {2'b00, d};
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: flop chain bringing an asynchronous bit into the clk domain.
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {DEPTH{RST_VAL}};
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver pushing characters and
// error flags into the RX queue.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       rx,
  input  logic [1:0] parity_type,
  input  logic [1:0] data_bits_count,
  input  logic       double_stop_bits,
  input  logic       rx_queue_full,
  output logic       rx_queue_we,
  output logic [7:0] rx_queue_din,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  logic rx_s;

  sync_ff #(
    .DEPTH  (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_sync (
    .clk_i(clk),
    .rst_i(reset),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  uart_rx_state_t  state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            par_q, par_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            armed_q, armed_d;
  rx_cfg_t         cfg_q, cfg_d;
  logic            we_q, we_d;
  logic            ovr_q, ovr_d;
  logic [7:0]      dout_q, dout_d;
  logic            operr_q, operr_d;
  logic            oferr_q, oferr_d;

  logic [3:0]      nbits;
  logic [7:0]      shifted;
  logic            done;
  logic            fe;

  assign nbits   = data_bits_num(cfg_q.nbits);
  assign shifted = {rx_s, sh_q[7:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b0;
      cfg_q   <= '0;
      we_q    <= 1'b0;
      ovr_q   <= 1'b0;
      dout_q  <= '0;
      operr_q <= 1'b0;
      oferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      armed_q <= armed_d;
      cfg_q   <= cfg_d;
      we_q    <= we_d;
      ovr_q   <= ovr_d;
      dout_q  <= dout_d;
      operr_q <= operr_d;
      oferr_q <= oferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    armed_d = armed_q;
    cfg_d   = cfg_q;
    we_d    = 1'b0;
    ovr_d   = 1'b0;
    dout_d  = dout_q;
    operr_d = operr_q;
    oferr_d = oferr_q;
    done    = 1'b0;
    fe      = ferr_q;

    if (sample_tick) begin
      tick_d = tick_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          tick_d = '0;
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            armed_d = 1'b0;
            state_d = START;
          end
        end
        START: begin
          if (tick_q == HALF) begin
            tick_d = '0;
            if (rx_s) begin
              armed_d = 1'b1;
              state_d = IDLE;
            end else begin
              cfg_d = '{parity:   parity_t'(parity_type),
                        nbits:    data_bits_t'(data_bits_count),
                        two_stop: double_stop_bits};
              bit_d   = '0;
              sh_d    = '0;
              par_d   = 1'b0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (tick_q == LAST) begin
            sh_d  = shifted;
            par_d = par_q ^ rx_s;
            bit_d = bit_q + 3'd1;
            if ({1'b0, bit_q} == nbits - 4'd1) begin
              // LSB-first shifting leaves short characters MSB-aligned
              sh_d    = shifted >> (4'd8 - nbits);
              state_d = cfg_q.parity[1] ? PARITY : STOP1;
            end
          end
        end
        PARITY: begin
          if (tick_q == LAST) begin
            perr_d  = par_q ^ rx_s ^ cfg_q.parity[0];
            state_d = STOP1;
          end
        end
        STOP1: begin
          if (tick_q == LAST) begin
            ferr_d = ~rx_s;
            fe     = ~rx_s;
            if (cfg_q.two_stop) state_d = STOP2;
            else                done    = 1'b1;
          end
        end
        STOP2: begin
          if (tick_q == LAST) begin
            fe     = ferr_q | ~rx_s;
            ferr_d = fe;
            done   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (done) begin
      state_d = IDLE;
      // a low stop bit may be a break; wait for the line to go high
      armed_d = ~fe;
      if (rx_queue_full) begin
        ovr_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        dout_d  = sh_q;
        operr_d = perr_q;
        oferr_d = fe;
      end
    end
  end

  assign rx_queue_we  = we_q;
  assign rx_queue_din = dout_q;
  assign parity_err   = operr_q;
  assign frame_err    = oferr_q;
  assign overrun      = ovr_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames against a frame-level model
// of the receiver's pushes, flags and push timing.
module tb_uart_rx;

  localparam int OS   = 16;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic       rx;
  logic [1:0] parity_type;
  logic [1:0] data_bits_count;
  logic       double_stop_bits;
  logic       rx_queue_full;
  logic       rx_queue_we;
  logic [7:0] rx_queue_din;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ovr_cnt  = 0;
  int exp_ovr  = 0;

  typedef struct packed {
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    logic [31:0] c;
  } push_t;

  push_t obs_q[$];
  push_t exp_q[$];

  uart_rx #(
    .OVERSAMPLE (OS),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sample_tick     (sample_tick),
    .rx              (rx),
    .parity_type     (parity_type),
    .data_bits_count (data_bits_count),
    .double_stop_bits(double_stop_bits),
    .rx_queue_full   (rx_queue_full),
    .rx_queue_we     (rx_queue_we),
    .rx_queue_din    (rx_queue_din),
    .parity_err      (parity_err),
    .frame_err       (frame_err),
    .overrun         (overrun),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin : mon
    push_t p;
    if (rx_queue_we) begin
      p.d  = rx_queue_din;
      p.pe = parity_err;
      p.fe = frame_err;
      p.c  = 32'(cyc);
      obs_q.push_back(p);
    end
    if (overrun) ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    step(OS);
  endtask

  task automatic send(input logic [7:0] d, input int nb,
                      input logic [1:0] pt, input logic pflip,
                      input int ns, input logic [1:0] stops,
                      input logic junk);
    logic [7:0] dm;
    logic       pen, pbit, r, perr, ferr;
    int         start_cyc;
    push_t      e;
    dm = d;
    for (int i = nb; i < 8; i++) dm[i] = 1'b0;
    pen  = pt[1];
    pbit = (^dm) ^ pt[0] ^ pflip;
    r    = (^dm) ^ pbit;
    perr = pen && (pt[0] ? (r == 1'b0) : (r == 1'b1));
    ferr = (stops[0] == 1'b0) || (ns == 2 && stops[1] == 1'b0);
    parity_type      = pt;
    data_bits_count  = 2'(nb - 5);
    double_stop_bits = (ns == 2);
    start_cyc = cyc;
    bit_out(1'b0);
    if (junk) begin
      parity_type      = 2'($urandom);
      data_bits_count  = 2'($urandom);
      double_stop_bits = 1'($urandom);
    end
    for (int i = 0; i < nb; i++) bit_out(d[i]);
    if (pen) bit_out(pbit);
    bit_out(stops[0]);
    if (ns == 2) bit_out(stops[1]);
    if (rx_queue_full) begin
      exp_ovr++;
    end else begin
      e.d  = dm;
      e.pe = perr;
      e.fe = ferr;
      e.c  = 32'(start_cyc + SYNC + 1 + (nb + int'(pen) + ns) * OS + OS / 2);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    chk({tag, "_overrun"}, 32'(ovr_cnt), 32'(exp_ovr));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(obs_q[i].d), 32'(exp_q[i].d));
      chk($sformatf("%s_perr%0d", tag, i), 32'(obs_q[i].pe), 32'(exp_q[i].pe));
      chk($sformatf("%s_ferr%0d", tag, i), 32'(obs_q[i].fe), 32'(exp_q[i].fe));
      chk($sformatf("%s_time%0d", tag, i), obs_q[i].c, exp_q[i].c);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_we"}, 32'(rx_queue_we), 32'd0);
    chk({tag, "_din"}, 32'(rx_queue_din), 32'd0);
    chk({tag, "_perr"}, 32'(parity_err), 32'd0);
    chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
    chk({tag, "_ovr"}, 32'(overrun), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin : stim
    logic [7:0] rd;
    int         rnb, rns;
    logic [1:0] rpt, rstops;
    logic       rflip, rbad;

    reset            = 1'b1;
    rx               = 1'b1;
    sample_tick      = 1'b1;
    rx_queue_full    = 1'b0;
    parity_type      = 2'b00;
    data_bits_count  = 2'b11;
    double_stop_bits = 1'b0;
    step(3);
    @(negedge clk);
    chk_reset_outs("reset");
    step(1);
    reset = 1'b0;
    step(4);

    send(8'hA5, 8, 2'b00, 1'b0, 1, 2'b11, 1'b0);
    step(4);
    drain("8n1");

    send(8'h35, 7, 2'b10, 1'b1, 2, 2'b11, 1'b0);
    step(4);
    drain("7e2_bad_parity");

    send(8'h1F, 5, 2'b11, 1'b0, 1, 2'b00, 1'b0);
    rx = 1'b0;
    step(40 * OS);
    drain("5o1_break");
    rx = 1'b1;
    step(2 * OS);
    send(8'h0A, 5, 2'b11, 1'b0, 1, 2'b11, 1'b0);
    step(4);
    drain("5o1_after_break");

    rx = 1'b0;
    step(5);
    rx = 1'b1;
    @(negedge clk);
    chk("glitch_busy", 32'(busy), 32'd1);
    step(20);
    chk("glitch_idle", 32'(busy), 32'd0);
    drain("glitch");

    rx_queue_full = 1'b1;
    send(8'h3C, 8, 2'b00, 1'b0, 1, 2'b11, 1'b0);
    step(4);
    rx_queue_full = 1'b0;
    drain("overrun");
    chk("overrun_hold", {24'd0, rx_queue_din}, 32'h0A);
    chk("overrun_flags", {30'd0, parity_err, frame_err}, 32'd0);

    send(8'h00, 8, 2'b00, 1'b0, 1, 2'b11, 1'b0);
    send(8'hFF, 8, 2'b00, 1'b0, 1, 2'b11, 1'b0);
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outs("midframe_reset");
    step(2);
    reset = 1'b0;
    rx    = 1'b1;
    step(300);
    drain("back_to_back");

    for (int n = 0; n < 12; n++) begin
      rd     = 8'($urandom);
      rnb    = 5 + int'($urandom_range(0, 3));
      rpt    = 2'($urandom_range(0, 3));
      rflip  = ($urandom_range(0, 3) == 0);
      rns    = 1 + int'($urandom_range(0, 1));
      rstops = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
      rbad   = (rstops[0] == 1'b0) || (rns == 2 && rstops[1] == 1'b0);
      send(rd, rnb, rpt, rflip, rns, rstops, 1'b1);
      rx = 1'b1;
      if (rbad) step(OS + int'($urandom_range(0, 20)));
      else      step(int'($urandom_range(0, 20)));
    end
    step(8);
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART peripheral: mirrors the TX path on the input side. It synchronises the `rx` line and detects start bits by 16x oversampling. It samples data, parity and stop bits at mid-bit, then pushes each received character, with its error flags, into the RX queue (`fifo`, XLEN 8).

## Interface
- `OVERSAMPLE`, 16: sample ticks per bit period (power of two, ≥8).
- `SYNC_STAGES`, 2: flops in the `rx` input synchroniser.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sample_tick`  in  1  clock enable, one `clk` pulse per 1/OVERSAMPLE bit period (from the clock-divisor counter).
- `rx`  in  1  asynchronous serial line, idle high.
- `parity_type`  in  2  0x none, 10 even, 11 odd.
- `data_bits_count`  in  2  00=5, 01=6, 10=7, 11=8 data bits.
- `double_stop_bits`  in  1  1 = two stop bits expected.
- `rx_queue_full`  in  1  RX queue full flag.
- `rx_queue_we`  out  1  one-cycle push strobe to the RX queue.
- `rx_queue_din`  out  8  received character, right-justified, unused MSBs zero.
- `parity_err`  out  1  parity error of the character on `rx_queue_din`; valid with `rx_queue_we`.
- `frame_err`  out  1  stop-bit error of that character; valid with `rx_queue_we`.
- `overrun`  out  1  one-cycle pulse: a character was completed while `rx_queue_full` was high, and it was dropped.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rx` passes through SYNC_STAGES flops. These flops reset to 1. All logic below uses the synchronised `rx_s`.
- The tick counter (log2 OVERSAMPLE bits) and the bit counter (3 bits) advance only on `sample_tick`.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: armed only after `rx_s` has been seen high on at least one tick. When armed and `rx_s`=0 on a tick, clear the tick counter and go to START.
- START: after OVERSAMPLE/2 ticks, sample `rx_s`.
  - If it is 1 (glitch), return to IDLE.
  - Otherwise latch `parity_type`, `data_bits_count` and `double_stop_bits` into frame config, clear the bit counter and go to DATA.
  - Config changes mid-frame are ignored.
- DATA: every OVERSAMPLE ticks (mid-bit), shift `rx_s` into the shift register, LSB first. Running parity XORs each bit.
  - After N bits, right-justify so bit0 = first bit received and bits 7..N are zero.
  - Then go to PARITY if parity is enabled, otherwise STOP1.
- PARITY: sample one bit and XOR it into the running parity. Error conditions:
  - even: error if result is 1;
  - odd: error if result is 0.
- STOP1 / STOP2: sample at mid-bit. `frame_err` is set if any sampled stop bit is 0. STOP2 is entered only if `double_stop_bits` was latched.
- Completion: on the cycle after the last stop sample, return to IDLE.
  - If `rx_queue_full`=0, pulse `rx_queue_we` with data and flags.
  - If `rx_queue_full`=1, pulse `overrun`. `rx_queue_we` stays 0 and the character is lost.
- A character with parity or frame error is still pushed, with its flags set.
- After a frame error, IDLE is unarmed. A held-low line (break) therefore produces exactly one character, and the receiver waits for `rx_s`=1.

## Timing
- Reset values: state IDLE (unarmed), counters 0, shift register 0x00. All outputs 0: `rx_queue_we`, `rx_queue_din`, `parity_err`, `frame_err`, `overrun`, `busy`.
- Input latency: SYNC_STAGES `clk` cycles from `rx` to `rx_s`.
- Falling edge to START: first tick with `rx_s`=0.
- Bit k sample: (k+1)·OVERSAMPLE + OVERSAMPLE/2 ticks after the start edge is detected.
- `rx_queue_we`/`overrun`: registered, exactly 1 `clk` cycle after the final stop-sample tick.
- `rx_queue_din`/flags: hold until the next push.
- The receiver is back in IDLE at the middle of the final stop bit. A start bit directly after the stop bit is caught with up to OVERSAMPLE/2 ticks of margin.
- `reset` mid-frame: the frame is aborted immediately, with no push and no overrun.
- `sample_tick` stuck low: the FSM freezes with no timeouts.

## Structure
- `uart_pkg`:
  - `parity_t` (NONE, EVEN=2'b10, ODD=2'b11);
  - `data_bits_t` encoding;
  - `uart_rx_state_t` enum;
  - a function mapping `data_bits_t` to a count.
- `uart_tx` datapath/controller reuse the same package.
- Sub-module `sync_ff` (parameterised depth, reset value) for the `rx` synchroniser.

## Test plan
- For all tests, `sample_tick` is high every cycle, so one bit is 16 clk cycles.
- 8N1, send 0xA5 -> one `rx_queue_we` pulse 1 cycle after the stop mid-sample, `rx_queue_din`=0xA5, both flags 0.
- 7E2, send 0x35 with wrong parity bit -> push of 0x35 with `parity_err`=1 and `frame_err`=0. Exactly one push, after the second stop sample.
- 5O1, send 0x1F with stop bit 0 -> `rx_queue_din`=0x1F, `frame_err`=1. Then hold the line low for 40 bit times -> no further pushes. Release the line, send 0x0A -> push 0x0A, no errors.
- Glitch: `rx` low for 5 cycles, then high -> `busy` returns to 0 and no push occurs.
- `rx_queue_full`=1 during a frame containing 0x3C -> `overrun` pulses once, `rx_queue_we` stays 0.
- Back-to-back 8N1 characters 0x00 then 0xFF with zero idle time, and a reset asserted mid-way through a third frame:
  - the first two characters are pushed correctly;
  - the third character produces no push;
  - all outputs are 0 during reset.
